// File: rtl/scratchmem_arb.sv
// Round-robin arbiter that shares one 128-bit scratchpad port among NREQ requesters.
// Each held request becomes one single-cycle memory strobe, then the arbiter waits for the ack or a timeout.
module scratchmem_arb #(
  parameter int NREQ = 3,
  parameter int TMO  = 31
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       r_cyc_i,
  input  logic [NREQ-1:0]       r_stb_i,
  input  logic [NREQ-1:0]       r_we_i,
  input  logic [NREQ*16-1:0]    r_sel_i,
  input  logic [NREQ*18-1:0]    r_adr_i,
  input  logic [NREQ*128-1:0]   r_dat_i,
  input  logic [NREQ*8-1:0]     r_tid_i,
  output logic [NREQ-1:0]       r_ack_o,
  output logic [NREQ-1:0]       r_err_o,
  output logic [127:0]          r_dat_o,
  output logic [7:0]            r_tid_o,
  output logic                  m_cs_o,
  output logic                  m_cyc_o,
  output logic                  m_stb_o,
  output logic                  m_we_o,
  output logic [2:0]            m_cti_o,
  output logic [15:0]           m_sel_o,
  output logic [17:0]           m_adr_o,
  output logic [127:0]          m_dat_o,
  output logic [7:0]            m_tid_o,
  input  logic                  m_ack_i,
  input  logic [127:0]          m_dat_i,
  input  logic [7:0]            m_tid_i,
  output logic [NREQ-1:0]       gnt_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_gidx;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_err;
  logic [7:0]      r_cnt;
  logic            r_mstb;
  logic            r_mwe;
  logic [15:0]     r_msel;
  logic [17:0]     r_madr;
  logic [127:0]    r_mdat;
  logic [7:0]      r_mtid;

  logic [NREQ-1:0] w_pend;
  logic            w_found;
  logic [IW-1:0]   w_pidx;
  logic            w_done;
  logic [15:0]     w_sel_a [NREQ];
  logic [17:0]     w_adr_a [NREQ];
  logic [127:0]    w_dat_a [NREQ];
  logic [7:0]      w_tid_a [NREQ];

  // First pending index at or above rr, wrapping; MSB of the result flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] pend, input logic [IW-1:0] rr);
    logic [IW:0] res;
    logic [IW:0] sum;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (pend[sum[IW-1:0]]) res = {1'b1, sum[IW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    if (g == IW'(NREQ - 1)) return '0;
    return g + 1'b1;
  endfunction

  always_comb begin
    for (int n = 0; n < NREQ; n++) begin
      w_sel_a[n] = r_sel_i[16*n +: 16];
      w_adr_a[n] = r_adr_i[18*n +: 18];
      w_dat_a[n] = r_dat_i[128*n +: 128];
      w_tid_a[n] = r_tid_i[8*n +: 8];
    end
  end

  assign w_pend            = r_cyc_i & r_stb_i;
  assign {w_found, w_pidx} = rr_pick(w_pend, r_rr);
  // Memory acks only count while a transaction is outstanding; IDLE acks are strays.
  assign w_done            = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && m_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_gidx  <= '0;
      r_gnt   <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
      r_mstb  <= 1'b0;
      r_mwe   <= 1'b0;
      r_msel  <= '0;
      r_madr  <= '0;
      r_mdat  <= '0;
      r_mtid  <= '0;
    end else begin
      r_err  <= '0;
      r_mstb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gidx  <= w_pidx;
            r_gnt   <= NREQ'(1) << w_pidx;
            r_mwe   <= r_we_i[w_pidx];
            r_msel  <= w_sel_a[w_pidx];
            r_madr  <= w_adr_a[w_pidx];
            r_mdat  <= w_dat_a[w_pidx];
            r_mtid  <= w_tid_a[w_pidx];
            r_mstb  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          if (m_ack_i) begin
            r_gnt   <= '0;
            r_rr    <= rr_next(r_gidx);
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (m_ack_i) begin
            r_gnt   <= '0;
            r_rr    <= rr_next(r_gidx);
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            // WAIT lasts TMO cycles; the error pulse lands as the count reaches TMO.
            if (r_cnt == TMO_LAST) begin
              r_err   <= r_gnt;
              r_gnt   <= '0;
              r_rr    <= rr_next(r_gidx);
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign r_ack_o = w_done ? r_gnt : '0;
  assign r_err_o = r_err;
  assign r_dat_o = w_done ? m_dat_i : '0;
  assign r_tid_o = w_done ? m_tid_i : '0;
  assign m_cs_o  = r_mstb;
  assign m_cyc_o = r_mstb;
  assign m_stb_o = r_mstb;
  assign m_we_o  = r_mwe;
  assign m_cti_o = 3'b000;
  assign m_sel_o = r_msel;
  assign m_adr_o = r_madr;
  assign m_dat_o = r_mdat;
  assign m_tid_o = r_mtid;
  assign gnt_o   = r_gnt;

endmodule

// File: tb/tb_scratchmem_arb.sv
// Bench for scratchmem_arb: scripted vector table, hand-built reset and fairness sequences,
// and a randomized run against a transaction-timeline model of the arbiter.
`timescale 1ns/1ps
module tb_scratchmem_arb;
  localparam int N = 3;
  localparam int T = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       cyc, stb, we;
  logic [N*16-1:0]    sel;
  logic [N*18-1:0]    adr;
  logic [N*128-1:0]   wdat;
  logic [N*8-1:0]     tid;
  logic [N-1:0]       rack, rerr, gnt;
  logic [127:0]       rdat, mdat_o, mdat_i;
  logic [7:0]         rtid, mtid_o, mtid_i;
  logic               mcs, mcyc, mstb, mwe, mack;
  logic [2:0]         mcti;
  logic [15:0]        msel;
  logic [17:0]        madr;

  int n_vec = 0;
  int n_bad = 0;

  scratchmem_arb #(.NREQ(N), .TMO(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .r_cyc_i(cyc), .r_stb_i(stb), .r_we_i(we), .r_sel_i(sel), .r_adr_i(adr),
    .r_dat_i(wdat), .r_tid_i(tid),
    .r_ack_o(rack), .r_err_o(rerr), .r_dat_o(rdat), .r_tid_o(rtid),
    .m_cs_o(mcs), .m_cyc_o(mcyc), .m_stb_o(mstb), .m_we_o(mwe), .m_cti_o(mcti),
    .m_sel_o(msel), .m_adr_o(madr), .m_dat_o(mdat_o), .m_tid_o(mtid_o),
    .m_ack_i(mack), .m_dat_i(mdat_i), .m_tid_i(mtid_i),
    .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  wire [14:0]  w_ctrl = {mcs, mcyc, mstb, mcti, gnt, rack, rerr};
  wire [135:0] w_resp = {rdat, rtid};
  wire [170:0] w_fld  = {mwe, msel, madr, mdat_o, mtid_o};

  typedef struct {
    logic [N-1:0] cyc;
    logic         ack;
    logic [127:0] mdat;
    logic [7:0]   mtid;
    logic         stb;
    logic [N-1:0] gnt;
    logic [N-1:0] rack;
    logic [N-1:0] rerr;
    logic [127:0] rdat;
    logic [7:0]   rtid;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] ctrl_exp(input logic s, input logic [N-1:0] g,
                                           input logic [N-1:0] a, input logic [N-1:0] e);
    return {s, s, s, 3'b000, g, a, e};
  endfunction

  function automatic logic [170:0] req_fld(input int n);
    return {we[n], sel[16*n +: 16], adr[18*n +: 18], wdat[128*n +: 128], tid[8*n +: 8]};
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] c, input logic a, input logic [127:0] md,
                              input logic [7:0] mt, input logic s, input logic [N-1:0] g,
                              input logic [N-1:0] ra, input logic [N-1:0] re);
    vec_t v;
    v.cyc = c; v.ack = a; v.mdat = md; v.mtid = mt;
    v.stb = s; v.gnt = g; v.rack = ra; v.rerr = re;
    v.rdat = (ra != '0) ? md : '0;
    v.rtid = (ra != '0) ? mt : '0;
    return v;
  endfunction

  task automatic set_req(input int n, input logic w, input logic [15:0] s, input logic [17:0] a,
                         input logic [127:0] d, input logic [7:0] t);
    we[n] = w;
    sel[16*n +: 16]   = s;
    adr[18*n +: 18]   = a;
    wdat[128*n +: 128] = d;
    tid[8*n +: 8]     = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1; cyc = '0; stb = '0; mack = 1'b0; mdat_i = '0; mtid_i = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_random(input int cycles);
    bit           hold [N];
    logic [N-1:0] done_prev, pend, ea, ee, eg;
    logic         es, found;
    logic [170:0] efld;
    int           busy, g, tt, tl, free_from, rr_m, err_at, err_g, idx;
    done_prev = '0; busy = 0; g = 0; tt = 0; tl = 0; free_from = 0; rr_m = 0;
    err_at = -1; err_g = 0; efld = '0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      for (int i = 0; i < N; i++) begin
        if (done_prev[i]) hold[i] = 1'b0;
        if (!hold[i] && $urandom_range(0, 2) == 0) begin
          hold[i] = 1'b1;
          set_req(i, 1'($urandom), 16'($urandom), 18'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
        end
        cyc[i] = hold[i];
        stb[i] = hold[i];
      end
      // Arbitration happens in any cycle the arbiter sits in IDLE.
      if (busy == 0 && n >= free_from) begin
        pend = cyc & stb;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (rr_m + k) % N;
          if (!found && pend[idx]) begin found = 1'b1; g = idx; end
        end
        if (found) begin
          busy = 1; tt = n + 1; tl = $urandom_range(0, T + 2); efld = req_fld(g);
        end
      end
      ea = '0; ee = '0; eg = '0; es = 1'b0; mack = 1'b0;
      if (busy != 0 && n >= tt) begin
        eg = N'(1) << g;
        es = (n == tt);
        if (tl <= T && n == tt + tl) begin
          mack = 1'b1; mdat_i = {$urandom, $urandom, $urandom, $urandom}; mtid_i = 8'($urandom);
          ea = eg;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mack = 1'b1; mdat_i = {$urandom, $urandom, $urandom, $urandom}; mtid_i = 8'($urandom);
      end
      if (n == err_at) ee = N'(1) << err_g;
      #1;
      chk("rnd_ctrl", w_ctrl, ctrl_exp(es, eg, ea, ee));
      chk("rnd_resp", w_resp, (ea != '0) ? {mdat_i, mtid_i} : 136'h0);
      if (es) chk("rnd_fld", w_fld, efld);
      done_prev = ea | ee;
      if (ea != '0) begin
        busy = 0; rr_m = (g + 1) % N; free_from = n + 1;
      end else if (busy != 0 && n == tt + T) begin
        busy = 0; rr_m = (g + 1) % N; free_from = n + 1; err_at = n + 1; err_g = g;
      end
      tick;
    end
    cyc = '0; stb = '0; mack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic prev;
    rst = 1'b1; cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; wdat = '0; tid = '0;
    mack = 1'b0; mdat_i = '0; mtid_i = '0;

    // Rows: cyc, mem ack, mem dat, mem tid | strobe, grant, ack, err (rdat/rtid follow ack).
    tbl[0]  = mk(3'b000, 1'b1, {16{8'hFF}}, 8'h99, 1'b0, 3'b000, 3'b000, 3'b000);
    tbl[1]  = mk(3'b010, 1'b0, '0, 8'h00, 1'b0, 3'b000, 3'b000, 3'b000);
    tbl[2]  = mk(3'b010, 1'b0, '0, 8'h00, 1'b1, 3'b010, 3'b000, 3'b000);
    tbl[3]  = mk(3'b010, 1'b0, '0, 8'h00, 1'b0, 3'b010, 3'b000, 3'b000);
    tbl[4]  = mk(3'b010, 1'b0, '0, 8'h00, 1'b0, 3'b010, 3'b000, 3'b000);
    tbl[5]  = mk(3'b010, 1'b1, {16{8'hA5}}, 8'h17, 1'b0, 3'b010, 3'b010, 3'b000);
    tbl[6]  = mk(3'b101, 1'b0, '0, 8'h00, 1'b0, 3'b000, 3'b000, 3'b000);
    tbl[7]  = mk(3'b101, 1'b0, '0, 8'h00, 1'b1, 3'b100, 3'b000, 3'b000);
    tbl[8]  = mk(3'b101, 1'b1, 128'hDEAD_BEEF, 8'h44, 1'b0, 3'b100, 3'b100, 3'b000);
    tbl[9]  = mk(3'b001, 1'b0, '0, 8'h00, 1'b0, 3'b000, 3'b000, 3'b000);
    tbl[10] = mk(3'b001, 1'b0, '0, 8'h00, 1'b1, 3'b001, 3'b000, 3'b000);
    tbl[11] = mk(3'b001, 1'b0, '0, 8'h00, 1'b0, 3'b001, 3'b000, 3'b000);
    tbl[12] = mk(3'b001, 1'b0, '0, 8'h00, 1'b0, 3'b001, 3'b000, 3'b000);
    tbl[13] = mk(3'b001, 1'b0, '0, 8'h00, 1'b0, 3'b001, 3'b000, 3'b000);
    tbl[14] = mk(3'b001, 1'b0, '0, 8'h00, 1'b0, 3'b001, 3'b000, 3'b000);
    tbl[15] = mk(3'b001, 1'b0, '0, 8'h00, 1'b0, 3'b000, 3'b000, 3'b001);
    tbl[16] = mk(3'b000, 1'b0, '0, 8'h00, 1'b1, 3'b001, 3'b000, 3'b000);
    tbl[17] = mk(3'b000, 1'b1, 128'hCAFE, 8'h55, 1'b0, 3'b001, 3'b001, 3'b000);
    tbl[18] = mk(3'b000, 1'b0, '0, 8'h00, 1'b0, 3'b000, 3'b000, 3'b000);

    set_req(0, 1'b0, 16'hFFFF, 18'h00040, 128'h0, 8'h10);
    set_req(1, 1'b0, 16'hFFFF, 18'h00120, 128'h0, 8'h21);
    set_req(2, 1'b1, 16'h000F, 18'h00200, 128'h1122_3344, 8'h32);

    do_reset;
    #1;
    chk("reset_ctrl", w_ctrl, ctrl_exp(1'b0, '0, '0, '0));
    chk("reset_fld", w_fld, 171'h0);
    chk("reset_resp", w_resp, 136'h0);

    for (int i = 0; i < 19; i++) begin
      cyc = tbl[i].cyc; stb = tbl[i].cyc;
      mack = tbl[i].ack; mdat_i = tbl[i].mdat; mtid_i = tbl[i].mtid;
      #1;
      chk($sformatf("tbl%0d_ctrl", i), w_ctrl, ctrl_exp(tbl[i].stb, tbl[i].gnt, tbl[i].rack, tbl[i].rerr));
      chk($sformatf("tbl%0d_resp", i), w_resp, {tbl[i].rdat, tbl[i].rtid});
      if (tbl[i].stb) chk($sformatf("tbl%0d_fld", i), w_fld, req_fld(oh2idx(tbl[i].gnt)));
      tick;
    end
    mack = 1'b0;

    // Reset while waiting: the late ack must be dropped and rr must restart at 0.
    cyc = 3'b100; stb = 3'b100;
    #1; chk("rstw_idle", w_ctrl, ctrl_exp(1'b0, '0, '0, '0)); tick;
    #1; chk("rstw_issue", w_ctrl, ctrl_exp(1'b1, 3'b100, '0, '0)); tick;
    rst = 1'b1;
    #1; chk("rstw_wait", w_ctrl, ctrl_exp(1'b0, 3'b100, '0, '0)); tick;
    rst = 1'b0; cyc = '0; stb = '0; mack = 1'b1; mdat_i = 128'h77; mtid_i = 8'h66;
    #1; chk("rstw_ack_dropped", w_ctrl, ctrl_exp(1'b0, '0, '0, '0));
    chk("rstw_resp_zero", w_resp, 136'h0); tick;
    mack = 1'b0; cyc = 3'b011; stb = 3'b011;
    #1; chk("rstw_idle2", w_ctrl, ctrl_exp(1'b0, '0, '0, '0)); tick;
    #1; chk("rstw_rr0", w_ctrl, ctrl_exp(1'b1, 3'b001, '0, '0)); tick;
    mack = 1'b1; mdat_i = 128'h1234; mtid_i = 8'h5A;
    #1; chk("rstw_done", w_ctrl, ctrl_exp(1'b0, 3'b001, 3'b001, '0));
    chk("rstw_done_resp", w_resp, {128'h1234, 8'h5A}); tick;
    mack = 1'b0; cyc = '0; stb = '0; tick;

    // Fairness: everyone requests continuously, memory acks one cycle after each strobe.
    do_reset;
    cyc = 3'b111; stb = 3'b111; cnt = 0; prev = 1'b0;
    for (int c = 0; c < 60 && cnt < 6; c++) begin
      mack = prev;
      #1;
      if (mstb) begin
        chk($sformatf("rr_order%0d", cnt), gnt, N'(1) << (cnt % N));
        cnt++;
      end
      prev = mstb;
      tick;
    end
    chk("rr_grant_count", cnt, 6);
    cyc = '0; stb = '0; mack = 1'b0; tick;

    do_reset;
    run_random(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/scratchmem_arb.md
Name: scratchmem_arb

Overview:
- Round-robin arbiter and transaction sequencer that shares the single 128-bit scratchpad memory port among NREQ requesters (e.g. fetch, load/store, DMA).
- Converts each requester's held classic bus request into exactly one single-cycle memory strobe. The memory acknowledges every cycle its select stays high, so a held select would produce repeated acks.
- Waits for the memory ack, then returns ack, data and tid to the granted requester.
- A timeout converts a lost ack into an error pulse.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TMO, 31, max cycles in WAIT before error (1..255).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- r_cyc_i  in  NREQ  per-requester cycle
- r_stb_i  in  NREQ  per-requester strobe
- r_we_i  in  NREQ  per-requester write enable
- r_sel_i  in  NREQ*16  byte selects, requester n at [16n+15:16n]
- r_adr_i  in  NREQ*18  byte addresses
- r_dat_i  in  NREQ*128  write data
- r_tid_i  in  NREQ*8  transaction ids
- r_ack_o  out  NREQ  ack pulse
- r_err_o  out  NREQ  timeout error pulse
- r_dat_o  out  128  read data (shared, valid with r_ack_o)
- r_tid_o  out  8  returned tid (shared)
- m_cs_o  out  1  memory select
- m_cyc_o  out  1  memory cycle
- m_stb_o  out  1  memory strobe
- m_we_o  out  1  memory write enable
- m_cti_o  out  3  always 3'b000
- m_sel_o  out  16  memory byte selects
- m_adr_o  out  18  memory address
- m_dat_o  out  128  memory write data
- m_tid_o  out  8  memory tid
- m_ack_i  in  1  memory ack
- m_dat_i  in  128  memory read data
- m_tid_i  in  8  memory returned tid
- gnt_o  out  NREQ  one-hot current grant (0 in IDLE)

Behaviour:
- Request n is pending when r_cyc_i[n] & r_stb_i[n]. The requester holds all of its signals until r_ack_o[n] or r_err_o[n].
- States: IDLE, ISSUE, WAIT. Reset: state=IDLE, rr pointer=0, gnt_o=0, all m_* outputs 0, r_ack_o=0, r_err_o=0, timeout counter=0.
- IDLE:
  - If any request is pending, choose the first pending index searching upward from rr, wrapping modulo NREQ.
  - Register gnt_o and capture that requester's we/sel/adr/dat/tid into m_* registers; go to ISSUE.
  - If nothing is pending, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - m_cs_o = m_cyc_o = m_stb_o = 1.
  - Clear the counter; go to WAIT.
  - If m_ack_i is high in this cycle, treat it as the completion (same handling as WAIT).
- WAIT:
  - m_cs_o/m_cyc_o/m_stb_o = 0. m_adr/we/sel/dat/tid hold their values.
  - On m_ack_i: r_ack_o[g] = 1 combinationally in that cycle; r_dat_o = m_dat_i; r_tid_o = m_tid_i; rr <= (g+1) mod NREQ; gnt_o <= 0; go to IDLE.
  - Otherwise increment the counter. When the counter == TMO with no ack: r_err_o[g] pulses for 1 cycle (registered), rr advances, go to IDLE.
- r_dat_o/r_tid_o are 0 whenever no r_ack_o bit is set.
- m_ack_i while in IDLE is ignored and never forwarded.
- A requester that drops cyc while granted is still completed on the memory side; its ack is still pulsed and may be ignored by the requester.
- IDLE is re-entered after every transaction, so back-to-back transactions cost at least ISSUE + memory latency + 1 cycles.
- Fairness: a requester that keeps requesting is re-granted only after every other pending requester has been served once.
- rst_i in any state: next cycle is IDLE with all outputs at reset values. An in-flight memory ack after reset is dropped by the IDLE-ignore rule.

Test Plan:
- Single read: req1 read adr=0x00120, memory ack 3 cycles after strobe with dat=0xA5..A5, tid_i=0x17 → m_stb_o high exactly 1 cycle with m_adr_o=0x00120; r_ack_o=3'b010 for 1 cycle with r_dat_o=0xA5..A5 and r_tid_o=0x17; rr=2.
- Round robin: all 3 requesters request continuously from reset → grant order 0,1,2,0,1,2; no requester is granted twice in a row.
- Write, 1-cycle memory latency: req2 write sel=0x000F, dat=0x11223344 → m_we_o=1, m_sel_o=0x000F, single strobe, r_ack_o[2] pulse; no second strobe.
- Timeout: TMO=4, memory never acks → r_err_o[g] pulses 5 cycles after ISSUE (counter 0..4), r_ack_o stays 0, arbiter returns to IDLE.
- Stray ack: pulse m_ack_i while IDLE with no requests → r_ack_o stays 0, state stays IDLE.
- Reset mid-WAIT: assert rst_i in WAIT, then memory acks → gnt_o=0, no r_ack_o; the next request is arbitrated from rr=0.
